cavlc_bit_packer: RTL
=====================

CAVLC_BIT_PACKER -- requirements
Module: cavlc_bit_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port code_valid_i, input, 1 bit: a code word is presented.
REQ-004 SHALL have port code_ready_o, output, 1 bit: the packer can accept a code this cycle.
REQ-005 SHALL have port code_bits_i, input, 16 bits: code, right-justified; only the low code_len_i bits are meaningful.
REQ-006 SHALL have port code_len_i, input, 5 bits: code length, range 0..16.
REQ-007 SHALL have port flush_i, input, 1 bit: single-cycle request to drain and zero-pad the buffered bits.
REQ-008 SHALL have port word_valid_o, output, 1 bit: output word available.
REQ-009 SHALL have port word_ready_i, input, 1 bit: downstream accepts the word.
REQ-010 SHALL have port word_data_o, output, 32 bits: packed bits, MSB = earliest bit.
REQ-011 SHALL have port word_bytes_o, output, 3 bits: number of valid bytes in word_data_o, 1..4.
REQ-012 SHALL have port flush_done_o, output, 1 bit: one-cycle pulse when a flush completes.
REQ-013 SHALL have port total_bits_o, output, 32 bits: count of code bits accepted since reset, wrapping modulo 2^32.

Function
REQ-014 SHALL keep a 48-bit MSB-aligned accumulator acc and a 6-bit fill count cnt (0..47).
REQ-015 SHALL implement states RUN, DRAIN and DONE; reset state SHALL be RUN.
REQ-016 SHALL drive code_ready_o = (state==RUN) && (cnt<32).
REQ-017 SHALL, on code accept (code_valid_i && code_ready_o), append the low code_len_i bits of code_bits_i at acc position cnt, then set cnt += code_len_i and total_bits_o += code_len_i, visible the next cycle.
REQ-018 SHALL treat code_len_i=0 as accepted with no change to acc, cnt or total_bits_o.
REQ-019 SHALL treat code_len_i>16 as length 16.
REQ-020 SHALL assert word_valid_o whenever cnt>=32, in any state, with word_data_o=acc[47:16] and word_bytes_o=4.
REQ-021 SHALL, on word handshake (word_valid_o && word_ready_i) with cnt>=32, shift acc left by 32 with zero fill and set cnt -= 32.
REQ-022 SHALL hold word_data_o and word_bytes_o stable while word_valid_o=1 and word_ready_i=0.
REQ-023 SHALL, when flush_i=1 in RUN, enter DRAIN next cycle; a code accepted in the same cycle SHALL be packed before the drain.
REQ-024 SHALL ignore flush_i outside RUN.
REQ-025 SHALL, in DRAIN with 0<cnt<32, assert word_valid_o with word_data_o = top cnt bits of acc, zero-padded, and word_bytes_o=ceil(cnt/8); on handshake cnt SHALL become 0.
REQ-026 SHALL go from DRAIN to DONE when cnt==0, including when the flush starts with cnt==0.
REQ-027 SHALL assert flush_done_o for exactly one cycle in DONE, then return to RUN.
REQ-028 SHALL keep acc bits at positions >= cnt at zero at all times.
REQ-029 SHALL drive all outputs only from registered state, with no combinational path from any input to any output except word_valid_o/code_ready_o, which depend on state only.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set state=RUN, acc=0, cnt=0 and total_bits_o=0, and discard all buffered bits, including during DRAIN or a stalled output.
REQ-031 SHALL drive word_valid_o=0, word_data_o=0, word_bytes_o=0, flush_done_o=0 and code_ready_o=1 in the cycle after reset.

Verification
REQ-032 SHALL cover: 32 codes {bits=1, len=1} with word_ready_i=1 -> one word 0xFFFFFFFF, bytes=4, then cnt=0 and total_bits_o=32.
REQ-033 SHALL cover: code 6'b000101 len 6, then flush -> word 0x14000000, bytes=1, and flush_done_o pulses one cycle after the handshake.
REQ-034 SHALL cover: codes 0xFFFF/16, 0x0000/16, 0xABCD/16, then flush -> words 0xFFFF0000 (bytes 4) and 0xABCD0000 (bytes 2).
REQ-035 SHALL cover: word_ready_i=0 with cnt>=32 -> code_ready_o=0 and word_data_o unchanged for 10 cycles; releasing word_ready_i resumes normal operation.
REQ-036 SHALL cover: a code with len=0 -> accepted, total_bits_o unchanged; a flush with cnt=0 -> no word is emitted and flush_done_o pulses.
REQ-037 SHALL cover: rst asserted during DRAIN with a word pending -> next cycle word_valid_o=0, cnt=0, flush_done_o is never asserted, and the state is RUN.

Source files
------------

// File: rtl/cavlc_bit_packer.sv
// CAVLC bit packer: concatenates variable-length code words (0..16 bits)
// into 32-bit output words, MSB first, with a flush that drains and
// zero-pads whatever partial word is left in the accumulator.
module cavlc_bit_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        code_valid_i,
  output logic        code_ready_o,
  input  logic [15:0] code_bits_i,
  input  logic [4:0]  code_len_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_data_o,
  output logic [2:0]  word_bytes_o,
  output logic        flush_done_o,
  output logic [31:0] total_bits_o
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [47:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] total_q, total_d;

  logic [4:0]  lenSat;
  logic [16:0] lenMask;
  logic [15:0] codeMasked;
  logic [5:0]  shAmt;
  logic [47:0] placed;
  logic [5:0]  cntRound;
  logic        fullWord;
  logic        codeAccept;
  logic        wordHs;

  // Clamp the length, mask off unused code bits and line the code up at fill position cnt.
  always_comb begin
    lenSat     = (code_len_i > 5'd16) ? 5'd16 : code_len_i;
    lenMask    = (17'd1 << lenSat) - 17'd1;
    codeMasked = code_bits_i & lenMask[15:0];
    shAmt      = 6'd48 - cnt_q - {1'b0, lenSat};
    placed     = {32'd0, codeMasked} << shAmt;
  end

  // Output view and handshakes, all derived from registered state only.
  always_comb begin
    fullWord     = (cnt_q >= 6'd32);
    cntRound     = cnt_q + 6'd7;
    code_ready_o = (state_q == RUN) && !fullWord;
    word_valid_o = fullWord || ((state_q == DRAIN) && (cnt_q != 6'd0));
    word_data_o  = acc_q[47:16];
    if (fullWord) begin
      word_bytes_o = 3'd4;
    end else if (word_valid_o) begin
      word_bytes_o = cntRound[5:3];
    end else begin
      word_bytes_o = 3'd0;
    end
    flush_done_o = (state_q == DONE);
    total_bits_o = total_q;
    codeAccept   = code_valid_i && code_ready_o;
    wordHs       = word_valid_o && word_ready_i;
  end

  // Next accumulator, fill count, bit total and FSM state; accept and word handshake never coincide.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    state_d = state_q;

    if (wordHs) begin
      if (fullWord) begin
        acc_d = acc_q << 32;
        cnt_d = cnt_q - 6'd32;
      end else begin
        acc_d = 48'd0;
        cnt_d = 6'd0;
      end
    end

    if (codeAccept) begin
      acc_d   = acc_q | placed;
      cnt_d   = cnt_q + {1'b0, lenSat};
      total_d = total_q + {27'd0, lenSat};
    end

    case (state_q)
      RUN: begin
        if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == 6'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers with synchronous reset that drops any buffered bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      acc_q   <= 48'd0;
      cnt_q   <= 6'd0;
      total_q <= 32'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

endmodule
